// File: rtl/branch_predictor_table_if.sv
// Fetch/execute-side bundle of the branch predictor table: lookup request and
// registered prediction, resolve-time update, statistics and debug history.
interface branch_predictor_table_if #(
  parameter int XLEN       = 32,
  parameter int INDEX_BITS = 6,
  parameter int HIST_BITS  = 6,
  parameter int STAT_BITS  = 16
);
  logic                  lookup_valid;
  logic [XLEN-1:0]       lookup_pc;
  logic                  prediction_valid;
  logic                  prediction;
  logic [INDEX_BITS-1:0] prediction_index;
  logic                  update_valid;
  logic [INDEX_BITS-1:0] update_index;
  logic                  update_taken;
  logic                  update_predicted;
  logic                  stat_clear;
  logic [STAT_BITS-1:0]  branch_count;
  logic [STAT_BITS-1:0]  mispredict_count;
  logic [HIST_BITS-1:0]  ghr;

  // Pipeline side that issues lookups and resolves branches.
  modport master (
    output lookup_valid, lookup_pc, update_valid, update_index,
           update_taken, update_predicted, stat_clear,
    input  prediction_valid, prediction, prediction_index,
           branch_count, mispredict_count, ghr
  );

  // Predictor side.
  modport slave (
    input  lookup_valid, lookup_pc, update_valid, update_index,
           update_taken, update_predicted, stat_clear,
    output prediction_valid, prediction, prediction_index,
           branch_count, mispredict_count, ghr
  );
endinterface

// File: rtl/branch_predictor_table.sv
// Table of 2^INDEX_BITS saturating counters indexed by PC, optionally XORed with
// a non-speculative global history (gshare), plus resolve/mispredict statistics.
module branch_predictor_table #(
  parameter int XLEN       = 32,
  parameter int INDEX_BITS = 6,
  parameter int CTR_BITS   = 2,
  parameter int HIST_BITS  = 6,
  parameter int GSHARE     = 1,
  parameter int STAT_BITS  = 16
) (
  input logic                     clock,
  input logic                     reset_n,
  branch_predictor_table_if.slave bus
);
  localparam int ENTRIES = 1 << INDEX_BITS;

  typedef logic [CTR_BITS-1:0] ctr_t;

  localparam ctr_t                 CTR_MAX  = '1;
  localparam ctr_t                 CTR_INIT = CTR_MAX >> 1;
  localparam logic [STAT_BITS-1:0] STAT_MAX = '1;

  ctr_t                  table_q [ENTRIES];
  ctr_t                  table_d [ENTRIES];
  logic [HIST_BITS-1:0]  ghr_q, ghr_d;
  logic                  pred_valid_q, pred_valid_d;
  logic                  pred_q, pred_d;
  logic [INDEX_BITS-1:0] pred_index_q, pred_index_d;
  logic [STAT_BITS-1:0]  branch_count_q, branch_count_d;
  logic [STAT_BITS-1:0]  mispredict_count_q, mispredict_count_d;
  logic [INDEX_BITS-1:0] lookup_index;
  ctr_t                  upd_ctr;

  // Only the word-aligned index bits of the PC select an entry.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.lookup_pc[XLEN-1:INDEX_BITS+2], bus.lookup_pc[1:0]};

  // Index and read both use pre-update state, so a same-cycle update is invisible.
  always_comb begin
    lookup_index = bus.lookup_pc[INDEX_BITS+1:2];
    if (GSHARE != 0) lookup_index = lookup_index ^ INDEX_BITS'(ghr_q);
  end

  always_comb begin
    // NOTE: every comb output gets a default first, so no path can infer a latch.
    pred_valid_d = bus.lookup_valid;
    pred_d       = pred_q;
    pred_index_d = pred_index_q;
    if (bus.lookup_valid) begin
      pred_d       = table_q[lookup_index][CTR_BITS-1];
      pred_index_d = lookup_index;
    end
  end

  always_comb begin
    table_d = table_q;
    ghr_d   = ghr_q;
    upd_ctr = table_q[bus.update_index];
    if (bus.update_valid) begin
      if (bus.update_taken && upd_ctr != CTR_MAX) begin
        table_d[bus.update_index] = upd_ctr + ctr_t'(1);
      end else if (!bus.update_taken && upd_ctr != '0) begin
        table_d[bus.update_index] = upd_ctr - ctr_t'(1);
      end
      // Truncating the concatenation drops the oldest bit; also correct for HIST_BITS=1.
      ghr_d = HIST_BITS'({ghr_q, bus.update_taken});
    end
  end

  always_comb begin
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (bus.stat_clear) begin
      branch_count_d     = '0;
      mispredict_count_d = '0;
    end else if (bus.update_valid) begin
      if (branch_count_q != STAT_MAX) branch_count_d = branch_count_q + 1'b1;
      if (bus.update_taken != bus.update_predicted && mispredict_count_q != STAT_MAX) begin
        mispredict_count_d = mispredict_count_q + 1'b1;
      end
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the table is a flop array that must reset to weakly not-taken, so no SRAM.
      for (int i = 0; i < ENTRIES; i++) table_q[i] <= CTR_INIT;
      ghr_q              <= '0;
      pred_valid_q       <= 1'b0;
      pred_q             <= 1'b0;
      pred_index_q       <= '0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      table_q            <= table_d;
      ghr_q              <= ghr_d;
      pred_valid_q       <= pred_valid_d;
      pred_q             <= pred_d;
      pred_index_q       <= pred_index_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign bus.prediction_valid = pred_valid_q;
  assign bus.prediction       = pred_q;
  assign bus.prediction_index = pred_index_q;
  assign bus.ghr              = ghr_q;
  assign bus.branch_count     = branch_count_q;
  assign bus.mispredict_count = mispredict_count_q;
endmodule

// File: tb/tb_branch_predictor_table.sv
// Drives three predictor configurations (bimodal, gshare, gshare with 4-bit stats)
// with shared stimulus and checks them every cycle against a behavioural model.
module tb_branch_predictor_table;
  logic        clock = 1'b0;
  logic        reset_n;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        update_valid;
  logic [5:0]  update_index;
  logic        update_taken;
  logic        update_predicted;
  logic        stat_clear;
  bit          cmp_en;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  branch_predictor_table_if #(.XLEN(32), .INDEX_BITS(6), .HIST_BITS(6), .STAT_BITS(16)) if_b ();
  branch_predictor_table_if #(.XLEN(32), .INDEX_BITS(6), .HIST_BITS(6), .STAT_BITS(16)) if_g ();
  branch_predictor_table_if #(.XLEN(32), .INDEX_BITS(6), .HIST_BITS(6), .STAT_BITS(4))  if_s ();

  branch_predictor_table #(.XLEN(32), .INDEX_BITS(6), .CTR_BITS(2), .HIST_BITS(6),
    .GSHARE(0), .STAT_BITS(16)) dut_b (.clock(clock), .reset_n(reset_n), .bus(if_b));
  branch_predictor_table #(.XLEN(32), .INDEX_BITS(6), .CTR_BITS(2), .HIST_BITS(6),
    .GSHARE(1), .STAT_BITS(16)) dut_g (.clock(clock), .reset_n(reset_n), .bus(if_g));
  branch_predictor_table #(.XLEN(32), .INDEX_BITS(6), .CTR_BITS(2), .HIST_BITS(6),
    .GSHARE(1), .STAT_BITS(4))  dut_s (.clock(clock), .reset_n(reset_n), .bus(if_s));

  assign if_b.lookup_valid = lookup_valid;     assign if_g.lookup_valid = lookup_valid;
  assign if_s.lookup_valid = lookup_valid;
  assign if_b.lookup_pc = lookup_pc;           assign if_g.lookup_pc = lookup_pc;
  assign if_s.lookup_pc = lookup_pc;
  assign if_b.update_valid = update_valid;     assign if_g.update_valid = update_valid;
  assign if_s.update_valid = update_valid;
  assign if_b.update_index = update_index;     assign if_g.update_index = update_index;
  assign if_s.update_index = update_index;
  assign if_b.update_taken = update_taken;     assign if_g.update_taken = update_taken;
  assign if_s.update_taken = update_taken;
  assign if_b.update_predicted = update_predicted;
  assign if_g.update_predicted = update_predicted;
  assign if_s.update_predicted = update_predicted;
  assign if_b.stat_clear = stat_clear;         assign if_g.stat_clear = stat_clear;
  assign if_s.stat_clear = stat_clear;

  logic [31:0] d_pv [3], d_p [3], d_pi [3], d_ghr [3], d_bc [3], d_mc [3];
  assign d_pv[0]  = 32'(if_b.prediction_valid); assign d_pv[1]  = 32'(if_g.prediction_valid);
  assign d_pv[2]  = 32'(if_s.prediction_valid);
  assign d_p[0]   = 32'(if_b.prediction);       assign d_p[1]   = 32'(if_g.prediction);
  assign d_p[2]   = 32'(if_s.prediction);
  assign d_pi[0]  = 32'(if_b.prediction_index); assign d_pi[1]  = 32'(if_g.prediction_index);
  assign d_pi[2]  = 32'(if_s.prediction_index);
  assign d_ghr[0] = 32'(if_b.ghr);              assign d_ghr[1] = 32'(if_g.ghr);
  assign d_ghr[2] = 32'(if_s.ghr);
  assign d_bc[0]  = 32'(if_b.branch_count);     assign d_bc[1]  = 32'(if_g.branch_count);
  assign d_bc[2]  = 32'(if_s.branch_count);
  assign d_mc[0]  = 32'(if_b.mispredict_count); assign d_mc[1]  = 32'(if_g.mispredict_count);
  assign d_mc[2]  = 32'(if_s.mispredict_count);

  // Behavioural model: counters as integers 0..3, history as an integer mod 64.
  int m_ctr [3][64];
  int m_ghr [3], m_bc [3], m_mc [3], m_pi [3];
  bit m_pv [3], m_p [3];
  int gshare   [3] = '{0, 1, 1};
  int stat_max [3] = '{65535, 65535, 15};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int e = 0; e < 64; e++) m_ctr[k][e] = 1;
      m_ghr[k] = 0; m_bc[k] = 0; m_mc[k] = 0; m_pi[k] = 0;
      m_pv[k] = 0;  m_p[k] = 0;
    end
  endtask

  task automatic model_step();
    int idx, ui;
    for (int k = 0; k < 3; k++) begin
      if (lookup_valid) begin
        idx = int'((lookup_pc >> 2) % 64);
        if (gshare[k] != 0) idx = idx ^ m_ghr[k];
        m_pv[k] = 1;
        m_pi[k] = idx;
        m_p[k]  = (m_ctr[k][idx] >= 2);
      end else begin
        m_pv[k] = 0;
      end
      if (update_valid) begin
        ui = int'(update_index);
        if (update_taken) m_ctr[k][ui] = (m_ctr[k][ui] < 3) ? m_ctr[k][ui] + 1 : 3;
        else              m_ctr[k][ui] = (m_ctr[k][ui] > 0) ? m_ctr[k][ui] - 1 : 0;
        m_ghr[k] = (m_ghr[k] * 2 + int'(update_taken)) % 64;
      end
      if (stat_clear) begin
        m_bc[k] = 0;
        m_mc[k] = 0;
      end else if (update_valid) begin
        if (m_bc[k] < stat_max[k]) m_bc[k]++;
        if (update_taken != update_predicted && m_mc[k] < stat_max[k]) m_mc[k]++;
      end
    end
  endtask

  // One clock: model advances on the same edge as the DUTs; returns 1 time unit later.
  task automatic tick();
    @(posedge clock);
    if (reset_n) model_step();
    #1;
  endtask

  task automatic idle();
    lookup_valid = 0; lookup_pc = '0; update_valid = 0; update_index = '0;
    update_taken = 0; update_predicted = 0; stat_clear = 0;
  endtask

  task automatic do_reset();
    idle();
    reset_n = 0;
    model_reset();
    @(posedge clock);
    #1;
    reset_n = 1;
  endtask

  task automatic set_update(input int idx, input bit taken, input bit predicted);
    update_valid = 1; update_index = 6'(idx); update_taken = taken; update_predicted = predicted;
  endtask

  always @(negedge clock) begin
    if (cmp_en && reset_n) begin
      for (int k = 0; k < 3; k++) begin
        check($sformatf("prediction_valid[%0d]", k), d_pv[k], 32'(m_pv[k]));
        check($sformatf("prediction[%0d]", k), d_p[k], 32'(m_p[k]));
        check($sformatf("prediction_index[%0d]", k), d_pi[k], 32'(m_pi[k]));
        check($sformatf("ghr[%0d]", k), d_ghr[k], 32'(m_ghr[k]));
        check($sformatf("branch_count[%0d]", k), d_bc[k], 32'(m_bc[k]));
        check($sformatf("mispredict_count[%0d]", k), d_mc[k], 32'(m_mc[k]));
      end
    end
  end

  initial begin
    cmp_en = 0;
    idle();
    reset_n = 0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check("reset_pred_valid", 32'(if_g.prediction_valid), 32'd0);
    check("reset_branch_count", 32'(if_g.branch_count), 32'd0);
    reset_n = 1;
    cmp_en  = 1;

    // Lookup from a freshly reset table: weakly not-taken, word-aligned index.
    lookup_valid = 1; lookup_pc = 32'h40;
    tick();
    check("t1_valid", 32'(if_b.prediction_valid), 32'd1);
    check("t1_pred", 32'(if_b.prediction), 32'd0);
    check("t1_index", 32'(if_b.prediction_index), 32'd16);
    idle();

    // Saturation at both ends of a bimodal counter.
    set_update(16, 1, 0); tick(); tick(); idle();
    lookup_valid = 1; lookup_pc = 32'h40; tick(); idle();
    check("t2_pred_after_2t", 32'(if_b.prediction), 32'd1);
    set_update(16, 1, 1); tick(); idle();
    set_update(16, 0, 1); tick(); tick(); tick(); idle();
    lookup_valid = 1; lookup_pc = 32'h40; tick(); idle();
    check("t2_pred_after_3nt", 32'(if_b.prediction), 32'd0);
    set_update(16, 0, 0); tick();
    set_update(16, 1, 0); tick(); tick(); idle();
    lookup_valid = 1; lookup_pc = 32'h40; tick(); idle();
    check("t2_pred_floor_held", 32'(if_b.prediction), 32'd1);
    check("t2_ghr", 32'(if_g.ghr), 32'd3);

    // Gshare index from history T,T,N.
    do_reset();
    set_update(0, 1, 0); tick();
    set_update(0, 1, 0); tick();
    set_update(0, 0, 0); tick(); idle();
    check("t3_ghr", 32'(if_g.ghr), 32'h06);
    lookup_valid = 1; lookup_pc = 32'h40; tick(); idle();
    check("t3_gshare_index", 32'(if_g.prediction_index), 32'd22);
    check("t3_bimodal_index", 32'(if_b.prediction_index), 32'd16);

    // Same-cycle lookup and update of the same entry reads the old counter.
    do_reset();
    lookup_valid = 1; lookup_pc = 32'h40; set_update(16, 1, 0); tick();
    update_valid = 0;
    check("t4_old_value", 32'(if_b.prediction), 32'd0);
    tick(); idle();
    check("t4_new_value", 32'(if_b.prediction), 32'd1);

    // Statistics: 10 branches, 3 mispredicted, then clear beats an increment.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      set_update(i, i[0], (i % 3 == 2) ? !i[0] : i[0]);
      tick();
    end
    idle();
    check("t5_branch_count", 32'(if_g.branch_count), 32'd10);
    check("t5_mispredict_count", 32'(if_g.mispredict_count), 32'd3);
    set_update(5, 1, 0); stat_clear = 1; tick(); idle();
    check("t5_clear_branch", 32'(if_g.branch_count), 32'd0);
    check("t5_clear_mispredict", 32'(if_g.mispredict_count), 32'd0);

    // 4-bit statistics saturate; async reset mid-cycle clears outputs immediately.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      set_update(i, 1, 0);
      tick();
    end
    lookup_valid = 1; lookup_pc = 32'h44; update_valid = 0; tick(); idle();
    check("t6_sat_branch", 32'(if_s.branch_count), 32'd15);
    check("t6_sat_mispredict", 32'(if_s.mispredict_count), 32'd15);
    check("t6_wide_branch", 32'(if_g.branch_count), 32'd17);
    #2;
    reset_n = 0;
    model_reset();
    #1;
    check("t6_rst_valid", 32'(if_s.prediction_valid), 32'd0);
    check("t6_rst_pred", 32'(if_g.prediction), 32'd0);
    check("t6_rst_index", 32'(if_g.prediction_index), 32'd0);
    check("t6_rst_ghr", 32'(if_g.ghr), 32'd0);
    check("t6_rst_branch", 32'(if_s.branch_count), 32'd0);
    check("t6_rst_mispredict", 32'(if_s.mispredict_count), 32'd0);
    @(posedge clock);
    #1;
    reset_n = 1;
    lookup_valid = 1; lookup_pc = 32'h40; tick(); idle();
    check("t6_post_valid", 32'(if_b.prediction_valid), 32'd1);
    check("t6_post_pred", 32'(if_b.prediction), 32'd0);

    // Randomised traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      lookup_valid     = ($urandom_range(0, 9) < 7);
      lookup_pc        = $urandom();
      update_valid     = ($urandom_range(0, 9) < 6);
      update_index     = 6'($urandom());
      update_taken     = ($urandom_range(0, 3) != 0);
      update_predicted = 1'($urandom_range(0, 1));
      stat_clear       = ($urandom_range(0, 63) == 0);
      tick();
    end
    idle();
    tick();
    cmp_en = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
